// File: rtl/fetch_sequencer_if.sv
// Bundle of run-control, instruction-memory, decode-handshake and redirect signals
// seen by the fetch sequencer; master is the sequencer side, slave the surroundings.
interface fetch_sequencer_if #(
   parameter int ADDR_W  = 4,
   parameter int INSTR_W = 16,
   parameter int CNT_W   = 16
);
   logic               start;
   logic               halt_req;
   logic [ADDR_W-1:0]  imem_addr;
   logic [INSTR_W-1:0] imem_instr;
   logic               out_valid;
   logic               out_ready;
   logic [INSTR_W-1:0] out_instr;
   logic [ADDR_W-1:0]  out_pc;
   logic               redirect_valid;
   logic [ADDR_W-1:0]  redirect_target;
   logic               busy;
   logic               halted;
   logic [CNT_W-1:0]   fetch_count;

   modport master (
      input  start, halt_req, imem_instr, out_ready, redirect_valid, redirect_target,
      output imem_addr, out_valid, out_instr, out_pc, busy, halted, fetch_count
   );

   modport slave (
      output start, halt_req, imem_instr, out_ready, redirect_valid, redirect_target,
      input  imem_addr, out_valid, out_instr, out_pc, busy, halted, fetch_count
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller: reads the instruction memory combinationally,
// resolves local jumps, registers the fetched word and hands it to decode.
module fetch_sequencer #(
   parameter int              ADDR_W     = 4,
   parameter int              INSTR_W    = 16,
   parameter logic [3:0]      JMP_OPCODE = 4'b1011,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int              CNT_W      = 16
) (
   input  logic               clk,
   input  logic               rst,
   fetch_sequencer_if.master  io_fetch
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_HALTED = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [ADDR_W-1:0]   r_pc;
   logic                r_out_valid;
   logic [INSTR_W-1:0]  r_out_instr;
   logic [ADDR_W-1:0]   r_out_pc;
   logic [CNT_W-1:0]    r_fetch_count;

   logic                w_redirect;
   logic                w_is_jump;
   logic                w_busy;
   logic                w_halted;
   logic                w_load;
   logic                w_handshake;

   assign w_redirect = io_fetch.redirect_valid;
   assign w_is_jump  = (io_fetch.imem_instr[INSTR_W-1 -: 4] == JMP_OPCODE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // A redirect never changes state; a halting RUN waits until the output is drained.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE, S_HALTED: begin
            if (!w_redirect && io_fetch.start && !io_fetch.halt_req) begin
               w_state_next = S_RUN;
            end
         end
         S_RUN: begin
            if (!w_redirect && io_fetch.halt_req && !r_out_valid) begin
               w_state_next = S_HALTED;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_busy      = (r_state == S_RUN);
      w_halted    = (r_state == S_HALTED);
      w_handshake = r_out_valid && io_fetch.out_ready && !w_redirect;
      w_load      = w_busy && !io_fetch.halt_req && !w_redirect
                    && (!r_out_valid || io_fetch.out_ready);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc        <= RESET_PC;
         r_out_valid <= 1'b0;
         r_out_instr <= '0;
         r_out_pc    <= '0;
      end else if (w_redirect) begin
         r_pc        <= io_fetch.redirect_target;
         r_out_valid <= 1'b0;
      end else if (w_load) begin
         if (w_is_jump) begin
            // The jump itself is consumed here and leaves a one-cycle bubble.
            r_pc        <= io_fetch.imem_instr[ADDR_W-1:0];
            r_out_valid <= 1'b0;
         end else begin
            r_out_instr <= io_fetch.imem_instr;
            r_out_pc    <= r_pc;
            r_out_valid <= 1'b1;
            r_pc        <= r_pc + 1'b1;
         end
      end else if (w_handshake) begin
         r_out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_count <= '0;
      end else if (w_handshake && (r_fetch_count != {CNT_W{1'b1}})) begin
         r_fetch_count <= r_fetch_count + 1'b1;
      end
   end

   assign io_fetch.imem_addr   = r_pc;
   assign io_fetch.out_valid   = r_out_valid;
   assign io_fetch.out_instr   = r_out_instr;
   assign io_fetch.out_pc      = r_out_pc;
   assign io_fetch.busy        = w_busy;
   assign io_fetch.halted      = w_halted;
   assign io_fetch.fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed walk through the run/stall/redirect/halt/reset scenarios, then a random
// phase whose accepted instruction stream is checked against a program-walk model.
module tb_fetch_sequencer;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fetch_sequencer_if bus ();

   fetch_sequencer dut (
      .clk      (clk),
      .rst      (rst),
      .io_fetch (bus)
   );

   logic [15:0] mem [16];
   assign bus.imem_instr = mem[bus.imem_addr];

   int n_cmp = 0;
   int n_err = 0;

   logic [19:0] exp_q [$];
   logic        sb_en = 1'b0;
   int          hs_seen = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic present(input string name, input int pc, input int instr, input int cnt);
      check({name, "_valid"}, 32'(bus.out_valid), 1);
      check({name, "_pc"}, 32'(bus.out_pc), pc);
      check({name, "_instr"}, 32'(bus.out_instr), instr);
      check({name, "_count"}, 32'(bus.fetch_count), cnt);
   endtask

   // Scoreboard monitor: every handshake must match the next entry of the model stream.
   always @(negedge clk) begin
      if (sb_en && !rst && bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
         if (exp_q.size() == 0) begin
            check("sb_underflow", 1, 0);
         end else begin
            logic [19:0] e;
            e = exp_q.pop_front();
            check("sb_pc", 32'(bus.out_pc), 32'(e[19:16]));
            check("sb_instr", 32'(bus.out_instr), 32'(e[15:0]));
            check("sb_count", 32'(bus.fetch_count), 32'(hs_seen));
            hs_seen++;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        is_j [16];
      logic [3:0]  mpc;
      logic [3:0]  tgt;
      logic [15:0] w;
      int          cyc;
      int          halt_cnt;

      rst = 1'b1;
      bus.start = 1'b0;
      bus.halt_req = 1'b0;
      bus.out_ready = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_target = '0;
      for (int i = 0; i < 16; i++) mem[i] = 16'h1000 + 16'(i);
      mem[0] = 16'h5085;
      mem[1] = 16'h6587;
      mem[2] = 16'h000B;
      mem[3] = 16'hB000;
      step();
      step();
      check("rst_valid", 32'(bus.out_valid), 0);
      check("rst_instr", 32'(bus.out_instr), 0);
      check("rst_out_pc", 32'(bus.out_pc), 0);
      check("rst_pc", 32'(bus.imem_addr), 0);
      check("rst_count", 32'(bus.fetch_count), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_halted", 32'(bus.halted), 0);

      // Straight-line run into a jump back to 0
      rst = 1'b0;
      bus.out_ready = 1'b1;
      step();
      check("idle_hold_pc", 32'(bus.imem_addr), 0);
      check("idle_busy", 32'(bus.busy), 0);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      check("start_busy", 32'(bus.busy), 1);
      check("start_valid", 32'(bus.out_valid), 0);
      step(); present("run_c1", 0, 32'h5085, 0);
      step(); present("run_c2", 1, 32'h6587, 1);
      step(); present("run_c3", 2, 32'h000B, 2);
      step();
      check("jmp_bubble", 32'(bus.out_valid), 0);
      check("jmp_pc", 32'(bus.imem_addr), 0);
      check("jmp_count", 32'(bus.fetch_count), 3);
      step(); present("run_c5", 0, 32'h5085, 3);
      step(); present("run_c6", 1, 32'h6587, 4);

      // Stall at pc1
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         present("stall", 1, 32'h6587, 4);
         check("stall_pc", 32'(bus.imem_addr), 2);
      end
      mem[3] = 16'h3003;
      bus.out_ready = 1'b1;
      step(); present("unstall", 2, 32'h000B, 5);
      step(); present("pre_redir", 3, 32'h3003, 6);

      // Redirect flushes the pending pc3
      bus.redirect_valid = 1'b1;
      bus.redirect_target = 4'd6;
      step();
      bus.redirect_valid = 1'b0;
      check("redir_valid", 32'(bus.out_valid), 0);
      check("redir_count", 32'(bus.fetch_count), 6);
      check("redir_pc", 32'(bus.imem_addr), 6);
      step(); present("redir_tgt", 6, 32'h1006, 6);

      // Halt with a pending instruction held by backpressure
      bus.halt_req = 1'b1;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         present("halt_hold", 6, 32'h1006, 6);
         check("halt_hold_halted", 32'(bus.halted), 0);
         check("halt_hold_pc", 32'(bus.imem_addr), 7);
      end
      bus.out_ready = 1'b1;
      step();
      check("halt_drain_valid", 32'(bus.out_valid), 0);
      check("halt_drain_count", 32'(bus.fetch_count), 7);
      check("halt_drain_halted", 32'(bus.halted), 0);
      step();
      check("halted", 32'(bus.halted), 1);
      check("halted_busy", 32'(bus.busy), 0);
      check("halted_pc", 32'(bus.imem_addr), 7);
      step();
      check("halted_hold_pc", 32'(bus.imem_addr), 7);
      bus.halt_req = 1'b0;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      check("resume_busy", 32'(bus.busy), 1);
      check("resume_halted", 32'(bus.halted), 0);
      step(); present("resume", 7, 32'h1007, 7);

      // Redirect to 14 and wrap through 15 -> 0
      bus.redirect_valid = 1'b1;
      bus.redirect_target = 4'd14;
      step();
      bus.redirect_valid = 1'b0;
      check("wrap_flush_count", 32'(bus.fetch_count), 7);
      step(); present("wrap14", 14, 32'h100E, 7);
      step(); present("wrap15", 15, 32'h100F, 8);
      step(); present("wrap0", 0, 32'h5085, 9);
      step(); present("wrap1", 1, 32'h6587, 10);

      // Asynchronous reset between edges
      #1 rst = 1'b1;
      #1;
      check("arst_valid", 32'(bus.out_valid), 0);
      check("arst_pc", 32'(bus.imem_addr), 0);
      check("arst_count", 32'(bus.fetch_count), 0);
      check("arst_busy", 32'(bus.busy), 0);
      check("arst_out_pc", 32'(bus.out_pc), 0);

      // Random program: jumps always land on a non-jump word, so the stream never stalls forever
      bus.out_ready = 1'b0;
      for (int i = 0; i < 16; i++) is_j[i] = (i != 0) && ($urandom % 4 == 0);
      for (int i = 0; i < 16; i++) begin
         if (is_j[i]) begin
            do tgt = 4'($urandom); while (is_j[tgt]);
            mem[i] = {4'hB, 8'($urandom), tgt};
         end else begin
            w = 16'($urandom);
            if (w[15:12] == 4'hB) w[15] = 1'b0;
            mem[i] = w;
         end
      end
      mpc = 4'd0;
      while (exp_q.size() < 200) begin
         if (mem[mpc][15:12] == 4'hB) begin
            mpc = mem[mpc][3:0];
         end else begin
            exp_q.push_back({mpc, mem[mpc]});
            mpc = mpc + 4'd1;
         end
      end
      step();
      rst = 1'b0;
      hs_seen = 0;
      sb_en = 1'b1;
      bus.start = 1'b1;
      step();
      cyc = 0;
      halt_cnt = 0;
      while (exp_q.size() > 0 && cyc < 3000) begin
         bus.start = 1'b0;
         if (halt_cnt > 0) begin
            halt_cnt--;
            if (halt_cnt == 0) begin
               bus.halt_req = 1'b0;
               bus.start = 1'b1;
            end
         end else if ($urandom % 40 == 0) begin
            bus.halt_req = 1'b1;
            halt_cnt = 3 + int'($urandom % 4);
         end
         bus.out_ready = ($urandom % 10) < 7;
         step();
         cyc++;
      end
      bus.out_ready = 1'b0;
      bus.start = 1'b0;
      check("rand_drain", 32'(exp_q.size()), 0);
      check("rand_count", 32'(bus.fetch_count), 200);
      step();
      step();
      sb_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
